// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and fetch FSM feeding decode over a valid/ready handshake.
// Define FETCH_MISALIGN_EN to trap misaligned redirects in a sticky FAULT state.
module instruction_fetch #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc_out,
  output logic            instr_valid,
  input  logic            decode_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            misalign_fault
);

`ifdef FETCH_MISALIGN_EN
  typedef enum logic [1:0] {FETCH = 2'd0, HOLD = 2'd1, FAULT = 2'd2} state_t;
`else
  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;
`endif

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [XLEN-1:0] pc_out_reg, pc_out_next;
  logic [31:0]     instr_reg, instr_next;
  logic            squash_reg, squash_next;
  logic [XLEN-1:0] target_load;
  logic [XLEN-1:0] pc_plus4;

`ifdef FETCH_MISALIGN_EN
  logic fault_reg, fault_next;
  logic redirect_bad;
  assign target_load    = branch_target;
  assign redirect_bad   = branch_taken && (branch_target[1:0] != 2'b00);
  assign misalign_fault = fault_reg;
`else
  // Low target bits are dropped, so a misaligned redirect lands on the enclosing word.
  logic target_lsb_unused;
  assign target_load       = {branch_target[XLEN-1:2], 2'b00};
  assign target_lsb_unused = ^branch_target[1:0];
  assign misalign_fault    = 1'b0;
`endif

  assign pc_plus4    = pc_reg + XLEN'(4);
  assign imem_addr   = addr_reg;
  assign instr       = instr_reg;
  assign pc_out      = pc_out_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_opcode
      assign opcode[gi] = instr_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= FETCH;
      pc_reg     <= RESET_PC;
      addr_reg   <= RESET_PC;
      pc_out_reg <= RESET_PC;
      instr_reg  <= 32'h0000_0013;
      squash_reg <= 1'b0;
`ifdef FETCH_MISALIGN_EN
      fault_reg  <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      addr_reg   <= addr_next;
      pc_out_reg <= pc_out_next;
      instr_reg  <= instr_next;
      squash_reg <= squash_next;
`ifdef FETCH_MISALIGN_EN
      fault_reg  <= fault_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    addr_next   = addr_reg;
    pc_out_next = pc_out_reg;
    instr_next  = instr_reg;
    squash_next = squash_reg;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
`ifdef FETCH_MISALIGN_EN
    fault_next  = fault_reg;
`endif
    case (state_reg)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (branch_taken) begin
            pc_next     = target_load;
            addr_next   = target_load;
            squash_next = 1'b0;
          end else if (squash_reg) begin
            // Stale response from before a redirect: reissue at the redirected PC.
            addr_next   = pc_reg;
            squash_next = 1'b0;
          end else begin
            instr_next  = imem_rdata;
            pc_out_next = pc_reg;
            state_next  = HOLD;
          end
        end else if (branch_taken) begin
          // Keep the pending address on the bus until the memory answers.
          pc_next     = target_load;
          squash_next = 1'b1;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (branch_taken) begin
          pc_next    = target_load;
          addr_next  = target_load;
          state_next = FETCH;
        end else if (decode_ready) begin
          pc_next    = pc_plus4;
          addr_next  = pc_plus4;
          state_next = FETCH;
        end
      end
`ifdef FETCH_MISALIGN_EN
      FAULT: begin
        // Only an in-flight request is held up, until its response drains.
        imem_req = squash_reg;
        if (imem_ready) squash_next = 1'b0;
      end
`endif
      default: state_next = FETCH;
    endcase
`ifdef FETCH_MISALIGN_EN
    if (redirect_bad && (state_reg != FAULT)) begin
      state_next  = FAULT;
      fault_next  = 1'b1;
      squash_next = (state_reg == FETCH) && !imem_ready;
    end
`endif
    if (reset) imem_req = 1'b0;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: table-driven streaming plus hand sequences, scoreboarded deliveries.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        decode_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        misalign_fault;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .pc_out(pc_out),
    .instr_valid(instr_valid), .decode_ready(decode_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .misalign_fault(misalign_fault)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic        rdy;
    logic        drdy;
    logic        br;
    logic [31:0] tgt;
    logic        push;
    logic [31:0] push_pc;
    logic        exp_req;
    logic        exp_valid;
    logic [31:0] exp_addr;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] instr_for(input logic [31:0] a);
    return {a[24:0], 7'h00} ^ 32'h1234_5633 ^ {25'd0, a[8:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = instr_for(pc);
    sb.push_back(e);
  endtask

  task automatic drive(input logic rdy, input logic drdy, input logic br, input logic [31:0] tgt);
    imem_ready    = rdy;
    decode_ready  = drdy;
    branch_taken  = br;
    branch_target = tgt;
    imem_rdata    = instr_for(imem_addr);
    #1;
  endtask

  task automatic advance();
    exp_t e;
    if (instr_valid && decode_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got delivery pc %h expected none", pc_out);
      end else begin
        e = sb.pop_front();
        check("pc_out", pc_out, e.pc);
        check("instr", instr, e.ins);
        check("opcode", {25'd0, opcode}, {25'd0, e.ins[6:0]});
        $display("xfer pc=%h instr=%h", pc_out, instr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = '0;
    decode_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 1'b1, 1'b0, 32'h4};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 1'b1, 1'b0, 32'h8};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0};

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_fault", {31'd0, misalign_fault}, 32'd0);
    check("rst_pc_out", pc_out, 32'h0);
    reset = 1'b0;

    // streaming with memory and decode always ready
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rdy, vecs[i].drdy, vecs[i].br, vecs[i].tgt);
      if (vecs[i].push) push(vecs[i].push_pc);
      check("tbl_req", {31'd0, imem_req}, {31'd0, vecs[i].exp_req});
      check("tbl_valid", {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_req) check("tbl_addr", imem_addr, vecs[i].exp_addr);
      advance();
    end

    // memory answers after 3 wait cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, 32'hC);
      advance();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("wait_addr_last", imem_addr, 32'hC);
    push(32'hC);
    advance();

    // decode stalls 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_req", {31'd0, imem_req}, 32'd0);
      check("stall_pc_out", pc_out, 32'hC);
      check("stall_instr", instr, instr_for(32'hC));
      advance();
    end
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    advance();
    check("stall_next_addr", imem_addr, 32'h10);

    // redirect while the fetch of 0x10 is outstanding
    drive(1'b0, 1'b1, 1'b1, 32'h100);
    check("sq_addr0", imem_addr, 32'h10);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    check("sq_addr_held", imem_addr, 32'h10);
    check("sq_req_held", {31'd0, imem_req}, 32'd1);
    advance();
    check("sq_valid", {31'd0, instr_valid}, 32'd0);
    check("sq_new_addr", imem_addr, 32'h100);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'h100);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    advance();

    // redirect coinciding with a memory response
    drive(1'b1, 1'b1, 1'b1, 32'h20);
    check("br_rdy_addr", imem_addr, 32'h104);
    advance();
    check("br_rdy_valid", {31'd0, instr_valid}, 32'd0);
    check("br_rdy_new", imem_addr, 32'h20);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'h20);
    advance();

    // redirect and decode_ready together in HOLD at 0x20
    drive(1'b1, 1'b1, 1'b1, 32'h40);
    check("br_hold_pc", pc_out, 32'h20);
    advance();
    check("br_hold_addr", imem_addr, 32'h40);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'h40);
    advance();

    // PC wrap at top of address space
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    advance();
    check("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'hFFFF_FFFC);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    advance();
    check("wrap_addr_zero", imem_addr, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'h0);
    advance();

    // misaligned redirect
    drive(1'b1, 1'b1, 1'b1, 32'h102);
    advance();
`ifdef FETCH_MISALIGN_EN
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      check("fault_flag", {31'd0, misalign_fault}, 32'd1);
      check("fault_req", {31'd0, imem_req}, 32'd0);
      check("fault_valid", {31'd0, instr_valid}, 32'd0);
      advance();
    end
`else
    check("mis_addr", imem_addr, 32'h100);
    check("mis_fault", {31'd0, misalign_fault}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'h100);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
`endif

    // reset in the middle of a fetch
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    #1;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    advance();
    reset = 1'b0;
    #1;
    check("post_rst_req", {31'd0, imem_req}, 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);
    check("post_rst_fault", {31'd0, misalign_fault}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    push(32'h0);
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    advance();

    check("sb_left", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
